// File: rtl/bin_to_seg.sv
// bin_to_seg: converts a 14-bit binary value to four registered 7-segment digit patterns
// using a sequential double-dabble conversion.
module bin_to_seg #(
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [13:0] value,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [7:0]  seg_out_1,
    output logic [7:0]  seg_out_2,
    output logic [7:0]  seg_out_3,
    output logic [7:0]  seg_out_4
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] ENCODE = 2'd2;
    localparam logic [7:0] BLANK  = 8'hFF;
    localparam logic [7:0] DASH   = 8'hBF;

    logic [1:0]  state;
    logic [15:0] bcd;
    logic [13:0] bin;
    logic [3:0]  cnt;
    logic        ovf;
    logic [15:0] bcd_adj;
    logic        z3, z32, z321, blz;

    function automatic logic [7:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = BLANK;
        endcase
    endfunction

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++)
            bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    // A digit blanks only when it and every more significant digit are zero.
    assign blz  = (BLANK_LZ != 0);
    assign z3   = (bcd[15:12] == 4'd0);
    assign z32  = z3 && (bcd[11:8] == 4'd0);
    assign z321 = z32 && (bcd[7:4] == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bcd       <= '0;
            bin       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            seg_out_1 <= BLANK;
            seg_out_2 <= BLANK;
            seg_out_3 <= BLANK;
            seg_out_4 <= BLANK;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin   <= value;
                        bcd   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        ovf   <= (value > 14'd9999);
                        state <= (value > 14'd9999) ? ENCODE : SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj[14:0], bin, 1'b0};
                    cnt        <= cnt + 4'd1;
                    if (cnt == 4'd13)
                        state <= ENCODE;
                end
                ENCODE: begin
                    seg_out_1 <= ovf ? DASH : seg(bcd[3:0]);
                    seg_out_2 <= ovf ? DASH : (blz && z321) ? BLANK : seg(bcd[7:4]);
                    seg_out_3 <= ovf ? DASH : (blz && z32) ? BLANK : seg(bcd[11:8]);
                    seg_out_4 <= ovf ? DASH : (blz && z3) ? BLANK : seg(bcd[15:12]);
                    overflow  <= ovf;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin_to_seg.sv
// tb_bin_to_seg: randomized and directed checks of bin_to_seg (both blanking modes)
// against a decimal-arithmetic reference model.
module tb_bin_to_seg;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [13:0] value = '0;
    logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    logic [7:0]  a1, a2, a3, a4, b1, b2, b3, b4;
    logic [31:0] segs_a, segs_b;
    int          errors = 0;
    int          checks = 0;

    localparam logic [7:0] DIG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    localparam int PW [4] = '{1, 10, 100, 1000};

    always #5 clk = ~clk;

    bin_to_seg #(.BLANK_LZ(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value),
        .busy(busy_a), .done(done_a), .overflow(ovf_a),
        .seg_out_1(a1), .seg_out_2(a2), .seg_out_3(a3), .seg_out_4(a4)
    );

    bin_to_seg #(.BLANK_LZ(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value),
        .busy(busy_b), .done(done_b), .overflow(ovf_b),
        .seg_out_1(b1), .seg_out_2(b2), .seg_out_3(b3), .seg_out_4(b4)
    );

    assign segs_a = {a4, a3, a2, a1};
    assign segs_b = {b4, b3, b2, b1};

    // Expected {seg_out_4..seg_out_1}: decimal digits by division, blank when value < 10^pos.
    function automatic logic [31:0] model(input int v, input bit blz);
        logic [31:0] r;
        for (int p = 0; p < 4; p++)
            r[8*p +: 8] = (v > 9999) ? 8'hBF :
                          (blz && p > 0 && v < PW[p]) ? 8'hFF : DIG[(v / PW[p]) % 10];
        return r;
    endfunction

    // Called at a falling edge; returns cycles until done and cycles busy was seen high.
    task automatic run(input logic [13:0] v, output int lat, output int busy_n);
        start = 1'b1;
        value = v;
        @(negedge clk);
        start = 1'b0;
        value = 14'($urandom);
        lat = 1;
        busy_n = 0;
        while (!done_a && lat < 40) begin
            if (busy_a) busy_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (segs_a !== 32'hFFFFFFFF || segs_b !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL reset_segs: got %h/%h want ffffffff", segs_a, segs_b);
        end
        checks++;
        if ({busy_a, done_a, ovf_a, busy_b, done_b, ovf_b} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000000",
                     {busy_a, done_a, ovf_a, busy_b, done_b, ovf_b});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_known();
        int vals [6] = '{1234, 7, 1050, 9999, 10000, 0};
        int lat, bn;
        for (int i = 0; i < 6; i++) begin
            run(14'(vals[i]), lat, bn);
            checks++;
            if (lat != (vals[i] > 9999 ? 2 : 16) || bn != (vals[i] > 9999 ? 1 : 15)) begin
                errors++;
                $display("FAIL known_timing v=%0d: latency %0d busy %0d", vals[i], lat, bn);
            end
            checks++;
            if (segs_a !== model(vals[i], 1) || segs_b !== model(vals[i], 0)) begin
                errors++;
                $display("FAIL known_segs v=%0d: got %h/%h want %h/%h", vals[i],
                         segs_a, segs_b, model(vals[i], 1), model(vals[i], 0));
            end
            checks++;
            if (ovf_a !== (vals[i] > 9999) || ovf_b !== (vals[i] > 9999)) begin
                errors++;
                $display("FAIL known_ovf v=%0d: got %b%b", vals[i], ovf_a, ovf_b);
            end
            @(negedge clk);
            value = 14'($urandom);
            checks++;
            if (done_a !== 1'b0 || busy_a !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse v=%0d: done %b busy %b want 0 0", vals[i], done_a, busy_a);
            end
            repeat (3) @(negedge clk);
            checks++;
            if (segs_a !== model(vals[i], 1) || done_a !== 1'b0) begin
                errors++;
                $display("FAIL hold v=%0d: got %h done %b want %h", vals[i], segs_a, done_a,
                         model(vals[i], 1));
            end
        end
    endtask

    task automatic test_random();
        int lat, bn, v;
        for (int i = 0; i < 25; i++) begin
            v = int'($urandom_range(0, 16383));
            run(14'(v), lat, bn);
            checks++;
            if (segs_a !== model(v, 1) || segs_b !== model(v, 0) || ovf_a !== (v > 9999)
                || lat != (v > 9999 ? 2 : 16)) begin
                errors++;
                $display("FAIL random v=%0d: got %h/%h ovf %b lat %0d want %h/%h", v,
                         segs_a, segs_b, ovf_a, lat, model(v, 1), model(v, 0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bn;
        @(negedge clk);
        start = 1'b1;
        value = 14'd42;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        repeat (2) begin
            @(negedge clk);
            lat++;
        end
        start = 1'b1;
        value = 14'd8888;
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (!done_a && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 16 || segs_a !== model(42, 1) || segs_b !== model(42, 0)) begin
            errors++;
            $display("FAIL ignore_start: lat %0d got %h/%h want 16 %h/%h", lat, segs_a, segs_b,
                     model(42, 1), model(42, 0));
        end
        run(14'd8888, lat, bn);
        checks++;
        if (lat != 16 || bn != 15 || segs_a !== 32'h80808080 || segs_b !== 32'h80808080) begin
            errors++;
            $display("FAIL back_to_back: lat %0d busy %0d got %h/%h want 16 15 80808080",
                     lat, bn, segs_a, segs_b);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int lat, bn, pulses;
        start = 1'b1;
        value = 14'd1234;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (segs_a !== 32'hFFFFFFFF || segs_b !== 32'hFFFFFFFF || busy_a !== 1'b0
            || done_a !== 1'b0 || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got %h/%h busy %b done %b ovf %b", segs_a, segs_b,
                     busy_a, done_a, ovf_a);
        end
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_a || done_b || busy_a) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_no_done: %0d active cycles want 0", pulses);
        end
        rst_n = 1'b1;
        run(14'd305, lat, bn);
        checks++;
        if (lat != 16 || segs_a !== model(305, 1) || segs_b !== model(305, 0)) begin
            errors++;
            $display("FAIL after_reset: lat %0d got %h/%h want 16 %h/%h", lat, segs_a, segs_b,
                     model(305, 1), model(305, 0));
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_known();
        test_random();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
